// File: rtl/idli_sqi_fetch.sv
`default_nettype none
// idli_sqi_fetch: lock-step quad-I/O READ fetch from two SQI memories into a small instruction FIFO.
// Optional macro IDLI_FETCH_BUF2_EN selects a two-entry buffer (default one entry).

package idli_sqi_pkg;
  localparam int SQI_NUM = 2;
  typedef logic [3:0] sqi_data_t;
  typedef enum logic {SQI_MEM_LO = 1'b0, SQI_MEM_HI = 1'b1} sqi_mem_t;
endpackage

module idli_sqi_fetch
  import idli_sqi_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_oe,
  output sqi_data_t   o_sqi_data [SQI_NUM],
  input  sqi_data_t   i_sqi_data [SQI_NUM],
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic        o_instr_vld,
  output logic [15:0] o_instr,
  output logic [15:0] o_instr_pc,
  input  logic        i_instr_rdy
);

`ifdef IDLI_FETCH_BUF2_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  lo_q, lo_d;
  logic        cs_n_q, oe_q;
  sqi_data_t   nib_q, nib_d;
  logic        head_vld_q;
  logic [15:0] head_q, head_pc_q;
  logic        pop, push, room;
  logic [1:0]  count, count_after_pop;
  logic [15:0] word;

  assign pop  = head_vld_q & i_instr_rdy;
  assign word = {i_sqi_data[SQI_MEM_HI], i_sqi_data[SQI_MEM_LO], lo_q};

`ifdef IDLI_FETCH_BUF2_EN
  logic        tail_vld_q;
  logic [15:0] tail_q, tail_pc_q;
  assign count = {1'b0, head_vld_q} + {1'b0, tail_vld_q};
`else
  assign count = {1'b0, head_vld_q};
`endif

  assign count_after_pop = count - {1'b0, pop};
  assign room            = (count_after_pop < DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    lo_d    = lo_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (room) begin
          state_d = ST_CMD;
          cnt_d   = 3'd0;
        end
      end
      ST_CMD: begin
        if (cnt_q == 3'd1) begin
          state_d = ST_ADDR;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_ADDR: begin
        if (cnt_q == 3'd5) begin
          state_d = ST_DUMMY;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DUMMY: begin
        if (cnt_q == 3'd1) begin
          state_d = ST_DATA;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q[0] == 1'b0) begin
          // Phase 0 decides whether another word fits; pc still names it on abort.
          if (room) begin
            lo_d  = {i_sqi_data[SQI_MEM_HI], i_sqi_data[SQI_MEM_LO]};
            cnt_d = 3'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          push  = 1'b1;
          pc_d  = pc_q + 16'd1;
          cnt_d = 3'd0;
          if (pc_q == 16'hFFFF) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_redirect) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
      pc_d    = i_redirect_pc;
      push    = 1'b0;
    end
  end

  always_comb begin
    nib_d = 4'h0;
    case (state_d)
      ST_CMD:  nib_d = (cnt_d == 3'd0) ? 4'h0 : 4'h3;
      ST_ADDR: begin
        case (cnt_d)
          3'd2:    nib_d = pc_q[15:12];
          3'd3:    nib_d = pc_q[11:8];
          3'd4:    nib_d = pc_q[7:4];
          3'd5:    nib_d = pc_q[3:0];
          default: nib_d = 4'h0;
        endcase
      end
      default: nib_d = 4'h0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      pc_q    <= 16'h0000;
      lo_q    <= 8'h00;
      cs_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      nib_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      lo_q    <= lo_d;
      cs_n_q  <= (state_d == ST_IDLE);
      oe_q    <= (state_d == ST_CMD) || (state_d == ST_ADDR);
      nib_q   <= nib_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_vld_q <= 1'b0;
      head_q     <= 16'h0000;
      head_pc_q  <= 16'h0000;
`ifdef IDLI_FETCH_BUF2_EN
      tail_vld_q <= 1'b0;
      tail_q     <= 16'h0000;
      tail_pc_q  <= 16'h0000;
`endif
    end else if (i_redirect) begin
      head_vld_q <= 1'b0;
`ifdef IDLI_FETCH_BUF2_EN
      tail_vld_q <= 1'b0;
`endif
    end else begin
`ifdef IDLI_FETCH_BUF2_EN
      if (!head_vld_q || pop) begin
        if (tail_vld_q) begin
          head_vld_q <= 1'b1;
          head_q     <= tail_q;
          head_pc_q  <= tail_pc_q;
          tail_vld_q <= push;
          tail_q     <= word;
          tail_pc_q  <= pc_q;
        end else begin
          head_vld_q <= push;
          if (push) begin
            head_q    <= word;
            head_pc_q <= pc_q;
          end
        end
      end else if (push) begin
        tail_vld_q <= 1'b1;
        tail_q     <= word;
        tail_pc_q  <= pc_q;
      end
`else
      if (!head_vld_q || pop) begin
        head_vld_q <= push;
        if (push) begin
          head_q    <= word;
          head_pc_q <= pc_q;
        end
      end
`endif
    end
  end

  assign o_sqi_cs_n             = cs_n_q;
  assign o_sqi_oe               = oe_q;
  assign o_sqi_data[SQI_MEM_LO] = nib_q;
  assign o_sqi_data[SQI_MEM_HI] = nib_q;
  assign o_instr_vld            = head_vld_q;
  assign o_instr                = head_q;
  assign o_instr_pc             = head_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_idli_sqi_fetch.sv
`default_nettype none
// tb_idli_sqi_fetch: directed bench with an SQI memory model and an in-order pop scoreboard.

module tb_idli_sqi_fetch;

`ifdef IDLI_FETCH_BUF2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs_n, oe;
  logic [3:0]  sqi_out [2];
  logic [3:0]  sqi_in  [2];
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        vld;
  logic [15:0] instr, instr_pc;
  logic        rdy = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          mode = 0;
  int          mcnt = 0;
  logic [31:0] nib = '0;
  logic [15:0] w;
  logic [31:0] txn_log [$];
  int          lock_bad = 0;
  int          cs_high = 0;
  logic [15:0] mon_exp = 16'h0000;

  typedef struct {
    int          cyc;
    logic        vld;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        cs_n;
    logic        oe;
    logic [3:0]  dat;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  idli_sqi_fetch dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_sqi_cs_n    (cs_n),
    .o_sqi_oe      (oe),
    .o_sqi_data    (sqi_out),
    .i_sqi_data    (sqi_in),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_instr_vld   (vld),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .i_instr_rdy   (rdy)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (mode == 0 && a == 16'h0000) return 16'hA5C3;
    if (mode == 1 && a < 16'd4) return 16'h1111 * (a + 16'd1);
    return a ^ 16'hC0DE;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] last_txn();
    if (txn_log.size() == 0) return 32'hFFFF_FFFF;
    return txn_log[txn_log.size() - 1];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Memory pair: samples command/address mid-cycle, returns data on the falling edge.
  always @(negedge clk) begin
    if (rst || cs_n) begin
      mcnt      = 0;
      sqi_in[0] = 4'h0;
      sqi_in[1] = 4'h0;
    end else begin
      if (mcnt < 8) begin
        if (sqi_out[0] !== sqi_out[1] || oe !== 1'b1) lock_bad++;
        nib = {nib[27:0], sqi_out[0]};
        if (mcnt == 7) txn_log.push_back(nib);
      end else if (mcnt < 10) begin
        sqi_in[0] = 4'hF;
        sqi_in[1] = 4'hF;
      end else begin
        w = mem_word(nib[15:0] + 16'((mcnt - 10) / 2));
        if (((mcnt - 10) % 2) == 0) begin
          sqi_in[0] = w[3:0];
          sqi_in[1] = w[7:4];
        end else begin
          sqi_in[0] = w[11:8];
          sqi_in[1] = w[15:12];
        end
      end
      mcnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst && vld && rdy) begin
      chk("pop_pc", {16'h0, instr_pc}, {16'h0, mon_exp});
      chk("pop_instr", {16'h0, instr}, {16'h0, mem_word(mon_exp)});
      mon_exp = mon_exp + 16'd1;
    end
    if (!rst && cs_n && cyc >= 1 && cyc <= 20) cs_high++;
  end

  task automatic to_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input int m, input logic r);
    rst      = 1'b1;
    rdy      = r;
    redirect = 1'b0;
    mode     = m;
    repeat (2) @(posedge clk);
    #1;
    mon_exp  = 16'h0000;
    txn_log.delete();
    lock_bad = 0;
    cs_high  = 0;
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    mon_exp     = pc;
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  initial begin
    sqi_in[0] = 4'h0;
    sqi_in[1] = 4'h0;
    #2;

    // Reset values, first fetch, then back-pressure with rdy low.
    apply_reset(0, 1'b0);
    chk("rst_cs_n", {31'h0, cs_n}, 32'd1);
    chk("rst_oe", {31'h0, oe}, 32'd0);
    chk("rst_data_lo", {28'h0, sqi_out[0]}, 32'd0);
    chk("rst_data_hi", {28'h0, sqi_out[1]}, 32'd0);
    chk("rst_vld", {31'h0, vld}, 32'd0);
    chk("rst_instr", {16'h0, instr}, 32'd0);
    chk("rst_pc", {16'h0, instr_pc}, 32'd0);
    rst = 1'b0;
    to_cycle(12);
    chk("a_vld_c12", {31'h0, vld}, 32'd0);
    to_cycle(13);
    chk("a_vld_c13", {31'h0, vld}, 32'd1);
    chk("a_instr_c13", {16'h0, instr}, 32'h0000_A5C3);
    chk("a_pc_c13", {16'h0, instr_pc}, 32'd0);
    chk("a_cmd_addr", last_txn(), 32'h0300_0000);
    to_cycle(13 + 2 * (DEPTH - 1));
    chk("a_cs_low_last", {31'h0, cs_n}, 32'd0);
    to_cycle(14 + 2 * (DEPTH - 1));
    chk("a_cs_rise", {31'h0, cs_n}, 32'd1);
    to_cycle(30);
    chk("a_hold_vld", {31'h0, vld}, 32'd1);
    chk("a_hold_instr", {16'h0, instr}, 32'h0000_A5C3);
    chk("a_hold_pc", {16'h0, instr_pc}, 32'd0);
    chk("a_hold_cs", {31'h0, cs_n}, 32'd1);
    rdy = 1'b1;
    to_cycle(42);
    chk("a_restart_vld0", {31'h0, vld}, 32'd0);
    to_cycle(43);
    chk("a_restart_vld1", {31'h0, vld}, 32'd1);
    chk("a_restart_pc", {16'h0, instr_pc}, DEPTH);
    chk("a_restart_addr", last_txn(), 32'h0300_0000 | DEPTH);
    chk("a_txn_count", txn_log.size(), 32'd2);
    to_cycle(50);
    chk("a_pop_count", {16'h0, mon_exp}, 4 + DEPTH);
    chk("a_lockstep", lock_bad, 32'd0);

    // Streaming with rdy held high.
    tbl[0]  = '{0,  1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'h0};
    tbl[1]  = '{1,  1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'h0};
    tbl[2]  = '{2,  1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'h3};
    tbl[3]  = '{3,  1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'h0};
    tbl[4]  = '{8,  1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'h0};
    tbl[5]  = '{9,  1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'h0};
    tbl[6]  = '{12, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'h0};
    tbl[7]  = '{13, 1'b1, 16'h1111, 16'h0000, 1'b0, 1'b0, 4'h0};
    tbl[8]  = '{14, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'h0};
    tbl[9]  = '{15, 1'b1, 16'h2222, 16'h0001, 1'b0, 1'b0, 4'h0};
    tbl[10] = '{17, 1'b1, 16'h3333, 16'h0002, 1'b0, 1'b0, 4'h0};
    tbl[11] = '{19, 1'b1, 16'h4444, 16'h0003, 1'b0, 1'b0, 4'h0};
    apply_reset(1, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      to_cycle(tbl[i].cyc);
      chk($sformatf("s%0d_vld", tbl[i].cyc), {31'h0, vld}, {31'h0, tbl[i].vld});
      chk($sformatf("s%0d_cs_n", tbl[i].cyc), {31'h0, cs_n}, {31'h0, tbl[i].cs_n});
      chk($sformatf("s%0d_oe", tbl[i].cyc), {31'h0, oe}, {31'h0, tbl[i].oe});
      chk($sformatf("s%0d_data", tbl[i].cyc), {28'h0, sqi_out[0]}, {28'h0, tbl[i].dat});
      if (tbl[i].vld) begin
        chk($sformatf("s%0d_instr", tbl[i].cyc), {16'h0, instr}, {16'h0, tbl[i].instr});
        chk($sformatf("s%0d_pc", tbl[i].cyc), {16'h0, instr_pc}, {16'h0, tbl[i].pc});
      end
    end
    to_cycle(21);
    chk("s_cs_held_low", cs_high, 32'd0);

    // Redirect mid-ADDR, redirect on a push cycle, then PC wrap.
    apply_reset(2, 1'b1);
    rst = 1'b0;
    to_cycle(5);
    do_redirect(16'h1234);
    chk("r_cs_n_after", {31'h0, cs_n}, 32'd1);
    chk("r_vld_after", {31'h0, vld}, 32'd0);
    to_cycle(18);
    chk("r_vld_c18", {31'h0, vld}, 32'd0);
    to_cycle(19);
    chk("r_vld_c19", {31'h0, vld}, 32'd1);
    chk("r_pc_c19", {16'h0, instr_pc}, 32'h0000_1234);
    chk("r_instr_c19", {16'h0, instr}, 32'h0000_D2EA);
    chk("r_addr", last_txn(), 32'h0300_1234);
    to_cycle(20);
    do_redirect(16'hFFFF);
    chk("p_vld_after", {31'h0, vld}, 32'd0);
    chk("p_cs_n_after", {31'h0, cs_n}, 32'd1);
    to_cycle(33);
    chk("w_vld_c33", {31'h0, vld}, 32'd0);
    to_cycle(34);
    chk("w_vld_c34", {31'h0, vld}, 32'd1);
    chk("w_pc_c34", {16'h0, instr_pc}, 32'h0000_FFFF);
    chk("w_instr_c34", {16'h0, instr}, 32'h0000_3F21);
    chk("w_cs_rise", {31'h0, cs_n}, 32'd1);
    chk("w_addr_ffff", last_txn(), 32'h0300_FFFF);
    to_cycle(46);
    chk("w_vld_c46", {31'h0, vld}, 32'd0);
    to_cycle(47);
    chk("w_vld_c47", {31'h0, vld}, 32'd1);
    chk("w_pc_c47", {16'h0, instr_pc}, 32'd0);
    chk("w_instr_c47", {16'h0, instr}, 32'h0000_C0DE);
    chk("w_addr_zero", last_txn(), 32'h0300_0000);
    to_cycle(48);
    chk("w_pop_next", {16'h0, mon_exp}, 32'd1);
    chk("r_lockstep", lock_bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
